// File: rtl/ei_axi4_rst_seq.sv
// ei_axi4_rst_seq: programmable AXI reset pulse sequencer.
// Drives NUM_CH active-low reset outputs with single, periodic or random
// spaced pulses of programmable delay and width.
// Optional feature macro: EI_AXI4_RST_SEQ_LFSR_EN adds the random-delay mode
// (16-bit LFSR); without it mode 2'b10 behaves exactly like periodic mode.
// The random delay uses the low CNT_W bits of the LFSR (zero-extended when
// CNT_W exceeds 16).
//
// state     | meaning
// ST_IDLE   | waiting for start_i, outputs released
// ST_DELAY  | counting down the delay before the next pulse
// ST_ASSERT | masked reset outputs held low for the pulse width

module ei_axi4_rst_seq #(
    parameter int NUM_CH    = 2,
    parameter int CNT_W     = 8,
    parameter int CNT_SAT_W = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [1:0]           mode_i,
    input  logic [NUM_CH-1:0]    ch_mask_i,
    input  logic [CNT_W-1:0]     dly_i,
    input  logic [CNT_W-1:0]     width_i,
    output logic [NUM_CH-1:0]    aresetn_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_SAT_W-1:0] pulse_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ASSERT = 2'd2
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       dly_q;
    logic [CNT_W-1:0]       wid_m1_q;
    logic [NUM_CH-1:0]      mask_q;
    logic                   per_q;
    logic                   stop_q;
    logic [NUM_CH-1:0]      aresetn_q;
    logic                   busy_q;
    logic                   done_q;
    logic [CNT_SAT_W-1:0]   pcnt_q;

    logic [CNT_W-1:0]       dly_start_d;
    logic [CNT_W-1:0]       dly_reload_d;
    logic [CNT_W-1:0]       wid_m1_d;
    logic                   per_d;

`ifdef EI_AXI4_RST_SEQ_LFSR_EN
    logic [15:0]            lfsr_q;
    logic                   lfsr_fb;
    logic [CNT_W-1:0]       rnd_mask;
    logic                   rnd_q;

    // x^16+x^14+x^13+x^11+1, shifting toward bit 0
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    if (CNT_W <= 16) begin : g_rnd_narrow
        assign rnd_mask = lfsr_q[CNT_W-1:0];
    end else begin : g_rnd_wide
        assign rnd_mask = {{(CNT_W-16){1'b0}}, lfsr_q};
    end

    // Free-running LFSR, restarts from the fixed seed on reset
    always_ff @(posedge aclk) begin
        if (areset) lfsr_q <= 16'hACE1;
        else        lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end

    // Remember whether the running sequence uses randomised delays
    always_ff @(posedge aclk) begin
        if (areset)                            rnd_q <= 1'b0;
        else if (state_q == ST_IDLE && start_i) rnd_q <= (mode_i == 2'b10);
    end

    assign dly_start_d  = (mode_i == 2'b10) ? (dly_i & rnd_mask) : dly_i;
    assign dly_reload_d = rnd_q ? (dly_q & rnd_mask) : dly_q;
`else
    assign dly_start_d  = dly_i;
    assign dly_reload_d = dly_q;
`endif

    // A zero width still produces a one-cycle pulse; the counter holds width-1
    assign wid_m1_d = (width_i == '0) ? '0 : width_i - 1'b1;
    assign per_d    = (mode_i == 2'b01) || (mode_i == 2'b10);

    // Sequencer FSM with registered outputs
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dly_q     <= '0;
            wid_m1_q  <= '0;
            mask_q    <= '0;
            per_q     <= 1'b0;
            stop_q    <= 1'b0;
            aresetn_q <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pcnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        dly_q    <= dly_i;
                        wid_m1_q <= wid_m1_d;
                        mask_q   <= ch_mask_i;
                        per_q    <= per_d;
                        cnt_q    <= dly_start_d;
                        stop_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (stop_i) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        cnt_q     <= wid_m1_q;
                        aresetn_q <= ~mask_q;
                        state_q   <= ST_ASSERT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (cnt_q == '0) begin
                        aresetn_q <= '1;
                        if (pcnt_q != '1) pcnt_q <= pcnt_q + 1'b1;
                        if (!per_q || stop_q || stop_i) begin
                            stop_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= dly_reload_d;
                            state_q <= ST_DELAY;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        if (stop_i) stop_q <= 1'b1;
                    end
                end
                default: begin
                    aresetn_q <= '1;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign aresetn_o   = aresetn_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pulse_cnt_o = pcnt_q;

endmodule

// File: tb/tb_ei_axi4_rst_seq.sv
// Testbench for ei_axi4_rst_seq: directed scenarios plus randomized sequences,
// each checked against a timeline model of pulse start/end edges.
`timescale 1ns/1ps
module tb_ei_axi4_rst_seq;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 8;
    localparam int SAT_W   = 4;
    localparam int SAT_MAX = (1 << SAT_W) - 1;
    localparam logic [NUM_CH-1:0] ALL1 = '1;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic              start_i = 1'b0;
    logic              stop_i = 1'b0;
    logic [1:0]        mode_i = '0;
    logic [NUM_CH-1:0] ch_mask_i = '0;
    logic [CNT_W-1:0]  dly_i = '0;
    logic [CNT_W-1:0]  width_i = '0;
    logic [NUM_CH-1:0] aresetn_o;
    logic              busy_o;
    logic              done_o;
    logic [SAT_W-1:0]  pulse_cnt_o;

    int n_chk = 0;
    int n_err = 0;
    int base_cnt = 0;
    logic [15:0] lfsr_m = 16'hACE1;

    always #5 aclk = ~aclk;

    ei_axi4_rst_seq #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CNT_SAT_W(SAT_W)) u_dut (
        .aclk        (aclk),
        .areset      (areset),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .mode_i      (mode_i),
        .ch_mask_i   (ch_mask_i),
        .dly_i       (dly_i),
        .width_i     (width_i),
        .aresetn_o   (aresetn_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pulse_cnt_o (pulse_cnt_o)
    );

    // Reference LFSR: polynomial x^16+x^14+x^13+x^11+1 in right-shift form
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic [15:0] b;
        b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h0001;
        return (l >> 1) | (b << 15);
    endfunction

    // Model value present before each clock edge
    always @(posedge aclk) lfsr_m <= areset ? 16'hACE1 : lfsr_next(lfsr_m);

    function automatic int sat(input int x);
        return (x > SAT_MAX) ? SAT_MAX : x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    task automatic do_reset();
        areset  = 1'b1;
        start_i = 1'b0;
        stop_i  = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_aresetn", aresetn_o, ALL1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cnt", pulse_cnt_o, 0);
        areset   = 1'b0;
        base_cnt = 0;
    endtask

    // stop_i in IDLE must not change anything
    task automatic idle_stop();
        stop_i = 1'b1;
        repeat (3) begin
            @(posedge aclk);
            @(negedge aclk);
            chk("idle_stop_busy", busy_o, 0);
            chk("idle_stop_done", done_o, 0);
            chk("idle_stop_aresetn", aresetn_o, ALL1);
        end
        stop_i = 1'b0;
    endtask

    // Edge 0 samples start. Pulse i: DELAY entered at edge e, low from edge
    // e+d+1 for w edges; the next DELAY begins on the edge the pulse ends.
    // stop_k < 0: no stop (single only); otherwise stop is sampled at edge
    // e_k+1+stop_off (stop_off < 0 picks a random point in pulse k's window).
    task automatic do_seq(input logic [1:0] mode, input logic [NUM_CH-1:0] mask,
                          input logic [CNT_W-1:0] dly, input logic [CNT_W-1:0] wid,
                          input int stop_k, input int stop_off);
        int a_e[64];
        int f_e[64];
        int e, e_k, k, w, d, stop_t, end_t, np, ndone;
        bit per, rnd, act;
        logic [15:0] lv;
        logic [NUM_CH-1:0] exp_n;
        per = (mode == 2'b01) || (mode == 2'b10);
`ifdef EI_AXI4_RST_SEQ_LFSR_EN
        rnd = (mode == 2'b10);
`else
        rnd = 1'b0;
`endif
        w = (wid == '0) ? 1 : int'(wid);
        k = (stop_k < 0 || !per) ? 0 : stop_k;
        e = 0;
        e_k = 0;
        for (int i = 0; i <= k; i++) begin
            if (rnd) begin
                lv = lfsr_m;
                for (int j = 0; j < e; j++) lv = lfsr_next(lv);
                d = int'(lv[CNT_W-1:0] & dly);
                chk("rnd_dly_range", (d <= int'(dly)), 1);
            end else begin
                d = int'(dly);
            end
            if (i == k) e_k = e;
            a_e[i] = e + d + 1;
            f_e[i] = a_e[i] + w;
            e = f_e[i];
        end
        if (stop_k < 0) begin
            stop_t = -1;
            end_t  = f_e[k];
            np     = k + 1;
        end else begin
            if (stop_off < 0) stop_t = e_k + 1 + int'($urandom_range(f_e[k] - e_k - 1, 0));
            else              stop_t = e_k + 1 + stop_off;
            if (stop_t - 1 < a_e[k]) begin
                end_t = stop_t;
                np    = k;
            end else begin
                end_t = f_e[k];
                np    = k + 1;
            end
        end
        for (int t = 0; t <= end_t + 1; t++) begin
            if (t == 0) begin
                start_i   = 1'b1;
                stop_i    = 1'($urandom_range(1, 0));
                mode_i    = mode;
                ch_mask_i = mask;
                dly_i     = dly;
                width_i   = wid;
            end else begin
                start_i   = (t <= end_t) ? 1'($urandom_range(1, 0)) : 1'b0;
                stop_i    = (t == stop_t);
                mode_i    = 2'($urandom);
                ch_mask_i = NUM_CH'($urandom);
                dly_i     = CNT_W'($urandom);
                width_i   = CNT_W'($urandom);
            end
            @(posedge aclk);
            @(negedge aclk);
            act   = 1'b0;
            ndone = 0;
            for (int j = 0; j < np; j++) begin
                if (t >= a_e[j] && t < f_e[j]) act = 1'b1;
                if (f_e[j] <= t) ndone++;
            end
            exp_n = act ? ~mask : ALL1;
            chk("aresetn", aresetn_o, exp_n);
            chk("busy", busy_o, (t < end_t));
            chk("done", done_o, (t == end_t));
            chk("pulse_cnt", pulse_cnt_o, sat(base_cnt + ndone));
        end
        start_i  = 1'b0;
        stop_i   = 1'b0;
        base_cnt = sat(base_cnt + np);
    endtask

    // Block reset on the second cycle of a 5-cycle pulse
    task automatic mid_reset();
        mode_i = 2'b00; ch_mask_i = ALL1; dly_i = 1; width_i = 5;
        start_i = 1'b1; stop_i = 1'b0;
        @(posedge aclk); @(negedge aclk);
        start_i = 1'b0;
        @(posedge aclk); @(negedge aclk);
        @(posedge aclk); @(negedge aclk);
        chk("mr_low", aresetn_o, 0);
        areset = 1'b1;
        @(posedge aclk); @(negedge aclk);
        chk("mr_aresetn", aresetn_o, ALL1);
        chk("mr_busy", busy_o, 0);
        chk("mr_done", done_o, 0);
        chk("mr_cnt", pulse_cnt_o, 0);
        areset   = 1'b0;
        base_cnt = 0;
        @(posedge aclk); @(negedge aclk);
        chk("mr_done_after", done_o, 0);
        chk("mr_busy_after", busy_o, 0);
        chk("mr_aresetn_after", aresetn_o, ALL1);
    endtask

    initial begin
        @(negedge aclk);
        do_reset();
        idle_stop();
        do_seq(2'b00, 2'b01, 3, 4, -1, 0);
        do_seq(2'b00, 2'b11, 0, 0, -1, 0);
        do_reset();
        do_seq(2'b01, 2'b11, 2, 3, 1, 4);
        do_seq(2'b11, 2'b10, 1, 2, -1, 0);
        do_seq(2'b01, 2'b00, 1, 1, 2, -1);
        do_seq(2'b00, 2'b11, 8'hFF, 8'hFF, -1, 0);
        mid_reset();
        do_reset();
        do_seq(2'b10, 2'b11, 8'h0F, 2, 20, 0);
        do_reset();
        do_seq(2'b01, 2'b01, 1, 1, 20, 0);
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(1, 0) == 1) do_reset();
            do_seq(2'($urandom), NUM_CH'($urandom), CNT_W'($urandom_range(15, 0)),
                   CNT_W'($urandom_range(7, 0)), int'($urandom_range(5, 0)), -1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
